urv_scoreboard: RTL

- Per-register hazard scheduler for the uRV decode stage.
- Tracks destination registers of issued multi-cycle operations: loads, shifts, MUL, and later iterative divide.
- Raises a stall request to decode until every operand the next instruction needs can be forwarded.
- Replaces the fixed one-bubble hazard rule with latency-driven counters, including unbounded-latency ops released by writeback.

---
 rtl/urv_scoreboard_pkg.sv | 13 +
 rtl/urv_scoreboard_if.sv | 33 +++
 rtl/urv_sb_counter.sv | 30 +++
 rtl/urv_scoreboard.sv | 51 +++++
 4 files changed

// File: rtl/urv_scoreboard_pkg.sv
// urv_scoreboard_pkg: shared types and latency constants for the uRV hazard scoreboard.
//   SB_LAT_W          default per-register counter width
//   reg_idx_t         architectural register index
//   SB_LAT_*          issue latencies used by decode; all-ones means "wait for writeback"
package urv_scoreboard_pkg;
    localparam int SB_LAT_W = 3;
    typedef logic [4:0] reg_idx_t;
    localparam logic [SB_LAT_W-1:0] SB_LAT_NONE      = 3'd0;
    localparam logic [SB_LAT_W-1:0] SB_LAT_LOAD      = 3'd2;
    localparam logic [SB_LAT_W-1:0] SB_LAT_SHIFT     = 3'd2;
    localparam logic [SB_LAT_W-1:0] SB_LAT_MUL       = 3'd2;
    localparam logic [SB_LAT_W-1:0] SB_LAT_UNBOUNDED = '1;
endpackage

// File: rtl/urv_scoreboard_if.sv
// urv_scoreboard_if: decode/writeback bundle between the decode stage and the scoreboard.
//   d_*_i          decode instruction fields, issue and kill
//   wb_valid_i/wb_rd_i  writeback release of an unbounded-latency result
//   d_stall_req_o  combinational stall request back to decode
//   busy_o         per-register pending flags (bit 0 always 0)
//   master modport: decode side; slave modport: scoreboard side
interface urv_scoreboard_if import urv_scoreboard_pkg::*; #(parameter int LAT_W = SB_LAT_W);
    logic             d_valid_i;
    reg_idx_t         d_rs1_i;
    reg_idx_t         d_rs2_i;
    logic             d_use_rs1_i;
    logic             d_use_rs2_i;
    reg_idx_t         d_rd_i;
    logic             d_rd_write_i;
    logic [LAT_W-1:0] d_latency_i;
    logic             d_issue_i;
    logic             d_kill_i;
    logic             wb_valid_i;
    reg_idx_t         wb_rd_i;
    logic             d_stall_req_o;
    logic [31:0]      busy_o;

    modport master (
        output d_valid_i, d_rs1_i, d_rs2_i, d_use_rs1_i, d_use_rs2_i, d_rd_i, d_rd_write_i,
               d_latency_i, d_issue_i, d_kill_i, wb_valid_i, wb_rd_i,
        input  d_stall_req_o, busy_o
    );
    modport slave (
        input  d_valid_i, d_rs1_i, d_rs2_i, d_use_rs1_i, d_use_rs2_i, d_rd_i, d_rd_write_i,
               d_latency_i, d_issue_i, d_kill_i, wb_valid_i, wb_rd_i,
        output d_stall_req_o, busy_o
    );
endinterface

// File: rtl/urv_sb_counter.sv
// urv_sb_counter: one register's latency counter with allocate > release > count-down priority.
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   alloc_i         allocate this register with lat_i (caller guarantees lat_i >= 2)
//   lat_i           issue latency; all-ones parks the counter until released
//   rel_i           writeback targets this register
//   cnt_o           current counter value
module urv_sb_counter #(parameter int LAT_W = 3) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             alloc_i,
    input  logic [LAT_W-1:0] lat_i,
    input  logic             rel_i,
    output logic [LAT_W-1:0] cnt_o
);
    localparam logic [LAT_W-1:0] ONES = '1;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // Allocating L-1 makes the counter reach zero exactly L cycles after issue.
    always_comb
        cnt_d = alloc_i                        ? (lat_i == ONES ? ONES : lat_i - LAT_W'(1)) :
                (rel_i && cnt_q == ONES)       ? '0 :
                (cnt_q != '0 && cnt_q != ONES) ? cnt_q - LAT_W'(1) :
                                                 cnt_q;

    always_ff @(posedge clk_i)
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/urv_scoreboard.sv
// urv_scoreboard: per-register hazard scheduler that stalls decode until operands are forwardable.
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   sb (slave)      decode fields, issue/kill, writeback release, stall request and busy flags
// Optional: define URV_SCOREBOARD_WAW_EN to also stall a write to a register whose older
// write is still pending (needed once writebacks can retire out of order).
module urv_scoreboard import urv_scoreboard_pkg::*; #(parameter int LAT_W = SB_LAT_W) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    urv_scoreboard_if.slave sb
);
    logic [LAT_W-1:0] cnt [32];
    logic [31:0]      busy;
    logic             hit1, hit2, waw, stall, alloc_ok;

    // x0 has no counter; a constant zero keeps the read muxes uniform.
    assign cnt[0] = '0;

    // A stalled issue is a protocol error; refusing the allocation keeps state sane.
    assign alloc_ok = sb.d_issue_i && !sb.d_kill_i && sb.d_rd_write_i &&
                      sb.d_latency_i >= LAT_W'(2) && !stall;

    for (genvar i = 1; i < 32; i++) begin : g_cnt
        urv_sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk_i,
            .rst_n_i,
            .alloc_i (alloc_ok && sb.d_rd_i == reg_idx_t'(i)),
            .lat_i   (sb.d_latency_i),
            .rel_i   (sb.wb_valid_i && sb.wb_rd_i == reg_idx_t'(i)),
            .cnt_o   (cnt[i])
        );
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) busy[r] = cnt[r] != '0;
    end

    always_comb begin
        hit1  = sb.d_use_rs1_i && sb.d_rs1_i != '0 && cnt[sb.d_rs1_i] != '0;
        hit2  = sb.d_use_rs2_i && sb.d_rs2_i != '0 && cnt[sb.d_rs2_i] != '0;
`ifdef URV_SCOREBOARD_WAW_EN
        waw   = sb.d_rd_write_i && sb.d_rd_i != '0 && cnt[sb.d_rd_i] != '0;
`else
        waw   = 1'b0;
`endif
        stall = sb.d_valid_i && !sb.d_kill_i && (hit1 || hit2 || waw);
    end

    assign sb.d_stall_req_o = stall;
    assign sb.busy_o        = busy;
endmodule
